// File: rtl/tinker_fetch_queue_if.sv
// Bundle of the fetch front-end signals: instruction-memory request/response,
// branch redirect, decode handshake, and a debug view of the internal counters.
interface tinker_fetch_queue_if;
    // Handshakes: a request transfers when imem_req && imem_gnt at a rising edge;
    // imem_rvalid is unconditional (one in-order response per grant); a queue
    // entry transfers to decode when instr_valid && instr_ready at a rising edge.
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc4;
    logic        instr_ready;
    logic [4:0]  dbg_count;
    logic [4:0]  dbg_inflight;
    logic [4:0]  dbg_discard;
    logic        dbg_stopped;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc4,
        output dbg_count, dbg_inflight, dbg_discard, dbg_stopped,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc4,
        input  dbg_count, dbg_inflight, dbg_discard, dbg_stopped,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/tinker_fetch_queue.sv
// Sequential instruction fetch with an in-order return queue and branch redirect.
// Optional halt-word stop is enabled by defining TINKER_FETCH_HALT_STOP_EN.
module tinker_fetch_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [63:0] RESET_PC     = 64'h2000,
    parameter int          MAX_INFLIGHT = 4
) (
    input logic                  clk,
    input logic                  reset,
    tinker_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam int TW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic          stopped_q, stopped_d;

    logic [31:0]   q_instr [DEPTH];
    logic [63:0]   q_pc4   [DEPTH];
    logic [63:0]   tag_mem [MAX_INFLIGHT];

    logic [SW-1:0] occ, credit;
    logic          req, fire, head_valid, deq;
    logic          rsp_stale, rsp_err, enq, pop_tag;
    logic [63:0]   rsp_pc;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_INFLIGHT - 1)) ? '0 : p + TW'(1);
    endfunction

    // Queue space is reserved at grant time, so a granted word always has a slot.
    assign occ        = SW'(count_q) + SW'(inflight_q);
    assign credit     = SW'(inflight_q) + SW'(discard_q);
    assign req        = !reset && !bus.redirect && !stopped_q &&
                        (occ < SW'(DEPTH)) && (credit < SW'(MAX_INFLIGHT));
    assign fire       = req && bus.imem_gnt;
    assign head_valid = (count_q != '0);
    assign deq        = head_valid && bus.instr_ready;
    assign rsp_stale  = bus.imem_rvalid && (bus.redirect || (discard_q != '0));
    assign rsp_err    = bus.imem_rvalid && !rsp_stale && (count_q == CW'(DEPTH));
    assign enq        = bus.imem_rvalid && !rsp_stale && !rsp_err;
    assign pop_tag    = rsp_stale || enq;
    assign rsp_pc     = tag_mem[tag_rd_q];

`ifdef TINKER_FETCH_HALT_STOP_EN
    logic halt_word;
    assign halt_word = (bus.imem_rdata[31:27] == 5'h0f) && (bus.imem_rdata[3:0] == 4'h0);
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        stopped_d  = stopped_q;
        tag_wr_d   = fire    ? tag_next(tag_wr_q) : tag_wr_q;
        tag_rd_d   = pop_tag ? tag_next(tag_rd_q) : tag_rd_q;
        if (bus.redirect) begin
            // Everything still owed by memory becomes stale, minus what returns now.
            fetch_pc_d = bus.redirect_pc;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            inflight_d = '0;
            discard_d  = discard_q + inflight_q + CW'(fire) - CW'(bus.imem_rvalid);
            stopped_d  = 1'b0;
        end else begin
            if (fire)      fetch_pc_d = fetch_pc_q + 64'd4;
            if (rsp_stale) discard_d  = discard_q - CW'(1);
            if (enq)       wr_ptr_d   = wr_ptr_q + PW'(1);
            if (deq)       rd_ptr_d   = rd_ptr_q + PW'(1);
            inflight_d = inflight_q + CW'(fire) - CW'(enq);
            count_d    = count_q + CW'(enq) - CW'(deq);
`ifdef TINKER_FETCH_HALT_STOP_EN
            if (enq && halt_word) stopped_d = 1'b1;
`endif
        end
`ifndef TINKER_FETCH_HALT_STOP_EN
        stopped_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            stopped_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            stopped_q  <= stopped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[wr_ptr_q] <= bus.imem_rdata;
            q_pc4[wr_ptr_q]   <= rsp_pc + 64'd4;
        end
        if (fire) tag_mem[tag_wr_q] <= bus.imem_addr;
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.instr_valid  = head_valid;
    assign bus.instr        = head_valid ? q_instr[rd_ptr_q] : '0;
    assign bus.instr_pc4    = head_valid ? q_pc4[rd_ptr_q] : '0;
    assign bus.dbg_count    = 5'(count_q);
    assign bus.dbg_inflight = 5'(inflight_q);
    assign bus.dbg_discard  = 5'(discard_q);
    assign bus.dbg_stopped  = stopped_q;
endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for tinker_fetch_queue: in-order memory model with fixed latency
// and a grant budget, an in-order scoreboard on the decode side.
module tb_tinker_fetch_queue;
    localparam int W = 96;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tinker_fetch_queue_if bus();

    tinker_fetch_queue #(
        .DEPTH(4),
        .RESET_PC(64'h2000),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int          lat       = 1;
    int          budget    = 0;
    int          n_grants  = 0;
    int          mcyc      = 0;
    bit          halt_mode = 1'b0;
    logic [63:0] pend_addr[$];
    int          pend_due[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (halt_mode && a == 64'h2008) return 32'h7800_0000;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (pend_due.size() > 0 && pend_due[0] <= mcyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            bus.imem_gnt = (budget > 0);
            @(negedge clk);
            if (!reset && bus.imem_req && bus.imem_gnt) begin
                pend_addr.push_back(bus.imem_addr);
                pend_due.push_back(mcyc + lat);
                budget--;
                n_grants++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int cons_n     = 0;
    int cons_first = 0;
    int cons_last  = 0;

    task automatic push_exp(input logic [63:0] addr);
        exp_q.push_back({addr + 64'd4, mem_word(addr)});
    endtask

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_instr", 64'(bus.instr_valid), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("instr_pc4", bus.instr_pc4, e[95:32]);
                    check_eq("instr", 64'(bus.instr), 64'(e[31:0]));
                end
                if (cons_n == 0) cons_first = mcyc;
                cons_last = mcyc;
                cons_n++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Leaves the caller at the drive point of the first cycle after reset release.
    task automatic do_reset(input int l, input int b, input logic rdy);
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        exp_q.delete();
        lat      = l;
        budget   = b;
        n_grants = 0;
        cons_n   = 0;
        tick(2);
        bus.instr_ready = rdy;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        tick(2);
        to_neg();
        check_eq("rst_req",      64'(bus.imem_req),     64'd0);
        check_eq("rst_addr",     bus.imem_addr,         64'h2000);
        check_eq("rst_valid",    64'(bus.instr_valid),  64'd0);
        check_eq("rst_instr",    64'(bus.instr),        64'd0);
        check_eq("rst_pc4",      bus.instr_pc4,         64'd0);
        check_eq("rst_count",    64'(bus.dbg_count),    64'd0);
        check_eq("rst_inflight", 64'(bus.dbg_inflight), 64'd0);
        check_eq("rst_discard",  64'(bus.dbg_discard),  64'd0);
        check_eq("rst_stopped",  64'(bus.dbg_stopped),  64'd0);

        // Streaming, L=1, decode always ready.
        do_reset(1, 6, 1'b1);
        for (int i = 0; i < 6; i++) push_exp(64'h2000 + 64'(4 * i));
        to_neg();
        check_eq("t1_first_req",  64'(bus.imem_req), 64'd1);
        check_eq("t1_first_addr", bus.imem_addr,     64'h2000);
        tick(); to_neg();
        check_eq("t1_c1_valid", 64'(bus.instr_valid), 64'd0);
        tick(); to_neg();
        check_eq("t1_c2_valid", 64'(bus.instr_valid), 64'd1);
        check_eq("t1_c2_pc4",   bus.instr_pc4,        64'h2004);
        tick(2); to_neg();
        check_eq("t1_steady_count", 64'(bus.dbg_count), 64'd1);
        wait_drain(20, "t1");
        check_eq("t1_throughput", 64'(cons_last - cons_first), 64'd5);
        check_eq("t1_grants",     64'(n_grants),               64'd6);

        // Decode stalled: credit stops issue at DEPTH.
        do_reset(1, 8, 1'b0);
        for (int i = 0; i < 8; i++) push_exp(64'h2000 + 64'(4 * i));
        tick(8); to_neg();
        check_eq("t2_grants", 64'(n_grants),        64'd4);
        check_eq("t2_req",    64'(bus.imem_req),    64'd0);
        check_eq("t2_count",  64'(bus.dbg_count),   64'd4);
        check_eq("t2_valid",  64'(bus.instr_valid), 64'd1);
        check_eq("t2_pc4",    bus.instr_pc4,        64'h2004);
        tick();
        bus.instr_ready = 1'b1;
        wait_drain(30, "t2");
        check_eq("t2_grants_all", 64'(n_grants), 64'd8);

        // L=3, redirect with three requests outstanding.
        do_reset(3, 3, 1'b1);
        for (int i = 0; i < 3; i++) push_exp(64'h3000 + 64'(4 * i));
        tick(3);
        check_eq("t3_inflight", 64'(bus.dbg_inflight), 64'd3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h3000;
        budget          = 3;
        tick();
        bus.redirect = 1'b0;
        to_neg();
        check_eq("t3_req",     64'(bus.imem_req),    64'd1);
        check_eq("t3_addr",    bus.imem_addr,        64'h3000);
        check_eq("t3_valid",   64'(bus.instr_valid), 64'd0);
        check_eq("t3_discard", 64'(bus.dbg_discard), 64'd2);
        tick(3); to_neg();
        check_eq("t3_c7_valid", 64'(bus.instr_valid), 64'd0);
        tick(); to_neg();
        check_eq("t3_c8_valid", 64'(bus.instr_valid), 64'd1);
        check_eq("t3_c8_pc4",   bus.instr_pc4,        64'h3004);
        wait_drain(20, "t3");

        // Redirect coinciding with a response and an asserted grant.
        do_reset(2, 3, 1'b1);
        for (int i = 0; i < 3; i++) push_exp(64'h4000 + 64'(4 * i));
        tick(2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h4000;
        budget          = 3;
        to_neg();
        check_eq("t4_req_in_redirect", 64'(bus.imem_req), 64'd0);
        tick();
        bus.redirect = 1'b0;
        to_neg();
        check_eq("t4_discard",  64'(bus.dbg_discard),  64'd1);
        check_eq("t4_inflight", 64'(bus.dbg_inflight), 64'd0);
        check_eq("t4_req",      64'(bus.imem_req),     64'd1);
        check_eq("t4_addr",     bus.imem_addr,         64'h4000);
        check_eq("t4_valid",    64'(bus.instr_valid),  64'd0);
        wait_drain(20, "t4");

        // Halt word at 0x2008.
        halt_mode = 1'b1;
        do_reset(1, 6, 1'b1);
`ifdef TINKER_FETCH_HALT_STOP_EN
        for (int i = 0; i < 4; i++) push_exp(64'h2000 + 64'(4 * i));
        tick(8); to_neg();
        check_eq("t5_grants_halted", 64'(n_grants),        64'd4);
        check_eq("t5_req_halted",    64'(bus.imem_req),    64'd0);
        check_eq("t5_stopped",       64'(bus.dbg_stopped), 64'd1);
        tick();
        push_exp(64'h2000);
        push_exp(64'h2004);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h2000;
        tick();
        bus.redirect = 1'b0;
        to_neg();
        check_eq("t5_resume_req",     64'(bus.imem_req),    64'd1);
        check_eq("t5_resume_addr",    bus.imem_addr,        64'h2000);
        check_eq("t5_resume_stopped", 64'(bus.dbg_stopped), 64'd0);
        wait_drain(20, "t5");
        check_eq("t5_grants_all", 64'(n_grants), 64'd6);
`else
        for (int i = 0; i < 6; i++) push_exp(64'h2000 + 64'(4 * i));
        tick(10);
        check_eq("t5_grants",  64'(n_grants),        64'd6);
        check_eq("t5_stopped", 64'(bus.dbg_stopped), 64'd0);
        wait_drain(20, "t5");
`endif
        halt_mode = 1'b0;

        // Reset while requests are outstanding and the queue holds entries.
        do_reset(3, 8, 1'b0);
        tick(5);
        check_eq("t6_count_before", 64'(bus.dbg_count),   64'd2);
        check_eq("t6_valid_before", 64'(bus.instr_valid), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("t6_addr",  bus.imem_addr,         64'h2000);
        check_eq("t6_req",   64'(bus.imem_req),     64'd0);
        check_eq("t6_count", 64'(bus.dbg_count),    64'd0);
        do_reset(1, 2, 1'b1);
        push_exp(64'h2000);
        push_exp(64'h2004);
        wait_drain(20, "t6");
        check_eq("t6_grants", 64'(n_grants), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tinker_fetch_queue.md
# tinker_fetch_queue

Instruction fetch front end for the tinker pipeline. It generates sequential fetch addresses, issues requests to instruction memory, and buffers returned 32-bit instruction words in an in-order queue. Decode consumes the queue through a valid/ready handshake. Execute can redirect the stream on a taken branch, which discards queued and in-flight instructions.

## Interface

Parameters:
- DEPTH, 4 — queue entries; power of two, 2..16.
- RESET_PC, 64'h2000 — first fetch address after reset.
- MAX_INFLIGHT, 4 — maximum outstanding memory requests; at most DEPTH.

Ports (name, direction, width, meaning):
- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-high.
- imem_req  out  1  — fetch request valid.
- imem_addr  out  64  — byte address of the requested word.
- imem_gnt  in  1  — memory accepts the request this cycle.
- imem_rvalid  in  1  — response word valid; responses return in order, one per granted request, at least 1 cycle after the grant.
- imem_rdata  in  32  — response instruction word (little-endian assembled).
- redirect  in  1  — taken branch; restart fetch.
- redirect_pc  in  64  — new fetch address.
- instr_valid  out  1  — queue head valid.
- instr  out  32  — head instruction; 0 when queue is empty.
- instr_pc4  out  64  — head fetch address + 4; 0 when queue is empty.
- instr_ready  in  1  — decode accepts the head. A deassertion means decode is stalled.

## Operation

- State:
  - fetch_pc (64)
  - queue of {instr, pc4} with rd_ptr/wr_ptr and count (0..DEPTH)
  - inflight (0..MAX_INFLIGHT): live requests
  - discard (0..MAX_INFLIGHT): stale responses still to be dropped
  - tag FIFO of request addresses, depth MAX_INFLIGHT, so each response can be paired with its pc4
- Issue rule: imem_req = !redirect && (count + inflight < DEPTH) && (inflight + discard < MAX_INFLIGHT) && !stopped.
- imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 4 (64-bit wrap); inflight += 1; push address to tag FIFO.
- On imem_rvalid:
  - If discard > 0: discard -= 1, pop the tag, and drop the word.
  - Otherwise: enqueue {imem_rdata, tag+4}, inflight -= 1, and pop the tag.
- Dequeue on instr_valid && instr_ready. Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- Redirect takes priority over all other events that cycle:
  - queue is emptied (count = 0, pointers equal)
  - fetch_pc <= redirect_pc
  - discard <= discard + inflight, counting the current-cycle grant, minus any current-cycle discarded response; inflight <= 0
  - a response arriving in the redirect cycle is treated as stale
  - no request is issued that cycle
  - stopped clears
- The credit rule guarantees the queue never overflows. A response arriving with count == DEPTH is a protocol error; the response is dropped and the state otherwise holds.
- Reset mid-operation: all state returns to its reset values immediately. Responses from requests outstanding before reset are the memory's responsibility and must not be driven after reset.

## Timing

- Reset values:
  - imem_req 0 while reset is asserted
  - imem_addr RESET_PC
  - instr_valid 0, instr 0, instr_pc4 0
  - count, inflight, discard, stopped all 0
- First request is in the first cycle after reset deasserts.
- Latency: grant at cycle t with response at t+L gives instr_valid at t+L+1. There is no response-to-output bypass.
- Redirect asserted at cycle t:
  - instr_valid is 0 at t+1
  - the first request to redirect_pc is at t+1
  - the first new instruction is visible at t+2+L
- Sustained throughput is 1 instruction/cycle when L < MAX_INFLIGHT and decode is ready.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs except imem_req's dependence on redirect.

## Configuration

- TINKER_FETCH_HALT_STOP_EN defined:
  - When a non-discarded response with opcode [31:27] == 5'h0f and [3:0] == 4'h0 is enqueued, stopped is set and imem_req stays 0 until redirect.
  - Requests already in flight still complete and enqueue.
- Undefined: stopped is held at 0 and fetch continues past halt words.

## Test plan

- Reset, memory L=1, always ready → requests at 0x2000, 0x2004, …; instr_pc4 0x2004 on the first valid cycle, then one instruction per cycle.
- Decode ready held low, L=1, DEPTH=4 → exactly 4 grants, then imem_req=0; count=4; after ready rises, 4 instructions leave in order.
- L=3 with 3 requests in flight, redirect to 0x3000 → 3 stale responses dropped; the first valid instruction has instr_pc4 0x3004.
- Redirect in the same cycle as imem_rvalid and a grant → the response is dropped; discard accounts for the granted request; no wrong-path instruction reaches decode.
- With the macro, fetch 0x78000000 at 0x2008 → no further requests after the in-flight ones; a redirect to 0x2000 resumes fetch. Without the macro, fetch continues.
- Assert reset with 2 requests in flight and the queue partially full → instr_valid=0 and imem_addr=0x2000 in the same cycle; fetch restarts cleanly.
